// File: rtl/multicore_pkg.sv
// Shared types for the core-side AXI plumbing.
// Contents:
//   - AXI channel structs (ar/aw share one address-channel struct, plus w, r, b);
//   - arbiter FSM state enums for the read and write paths;
//   - one-hot grant encodings and a helper that maps an owner bit to a grant.
// Owner bit convention used throughout: 0 = instruction master, 1 = data master.
package multicore_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] GRANT_INSTR = 2'b01;
  localparam logic [1:0] GRANT_DATA  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } arb_rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } arb_wr_state_t;

  // Address channel (used for both ar and aw).
  typedef struct packed {
    logic                  valid;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_ax_t;

  typedef struct packed {
    logic                  valid;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic                  valid;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] resp;
  } axi_b_t;

  function automatic logic [1:0] grant_of(input logic owner);
    return owner ? GRANT_DATA : GRANT_INSTR;
  endfunction

endpackage

// File: rtl/axi_inf.sv
// Minimal AXI bundle connecting a cache controller, the arbiter and memory.
// Master drives: ar, aw, w, rready, bready.
// Slave drives:  arready, awready, wready, r, b.
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are high; a source keeps valid and its payload stable until then, and
// valid never waits on ready.
interface axi_inf;
  import multicore_pkg::*;

  axi_ax_t ar;
  logic    arready;
  axi_ax_t aw;
  logic    awready;
  axi_w_t  w;
  logic    wready;
  axi_r_t  r;
  logic    rready;
  axi_b_t  b;
  logic    bready;

  modport master (
    output ar, aw, w, rready, bready,
    input  arready, awready, wready, r, b
  );

  modport slave (
    input  ar, aw, w, rready, bready,
    output arready, awready, wready, r, b
  );
endinterface

// File: rtl/axi_rr_picker.sv
// Two-way picker with a last-winner register.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   req      : request vector, [0] instruction, [1] data
//   update   : pulse when the picked winner is actually granted
//   winner   : 0 = instruction, 1 = data (only meaningful when req != 0)
// With RR_ENABLE=1 a contention goes to the master that did not win last;
// with RR_ENABLE=0 data always beats instruction. A lone requester always wins.
module axi_rr_picker #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       winner
);

  // Reset to "instruction won last" so data takes the first contention.
  logic last_winner;

  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = RR_ENABLE ? ~last_winner : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= 1'b0;
    end else if (update) begin
      last_winner <= winner;
    end
  end

endmodule

// File: rtl/axi_core_arbiter.sv
// Merges the instruction-cache and data-cache AXI masters of a core onto one
// AXI master port. Read and write paths have independent FSMs and pickers;
// each grant covers one whole burst and is held until its final handshake.
// Ports:
//   i_aclk, i_areset : clock, synchronous active-high reset
//   s_instr, s_data  : upstream slave ports from the two cache controllers
//   m_axi            : merged downstream master port
//   o_rd_grant       : one-hot read owner ([0] instr, [1] data), 0 when idle
//   o_wr_grant       : one-hot write owner, same encoding
// Non-owners see ready/valid low; their r/b payload fields mirror m_axi and
// are don't-care. While nothing is in flight every downstream field is zero.
module axi_core_arbiter
  import multicore_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        i_aclk,
  input  logic        i_areset,
  axi_inf.slave       s_instr,
  axi_inf.slave       s_data,
  axi_inf.master      m_axi,
  output logic [1:0]  o_rd_grant,
  output logic [1:0]  o_wr_grant
);

  // ---------------------------------------------------------------- read path
  arb_rd_state_t rd_state;
  logic          rd_owner;
  logic [1:0]    rd_req;
  logic          rd_winner;
  logic          rd_start;
  axi_ax_t       rd_ar_sel;
  logic          rd_rready_sel;
  logic          rd_ar_hs;
  logic          rd_last_hs;

  assign rd_req        = {s_data.ar.valid, s_instr.ar.valid};
  assign rd_start      = (rd_state == RD_IDLE) && (|rd_req);
  assign rd_ar_sel     = rd_owner ? s_data.ar : s_instr.ar;
  assign rd_rready_sel = rd_owner ? s_data.rready : s_instr.rready;
  assign rd_ar_hs      = (rd_state == RD_ADDR) && m_axi.ar.valid && m_axi.arready;
  assign rd_last_hs    = (rd_state == RD_DATA) && m_axi.r.valid && m_axi.rready
                         && m_axi.r.last;

  axi_rr_picker #(.RR_ENABLE(RR_ENABLE)) u_rd_pick (
    .clk    (i_aclk),
    .rst    (i_areset),
    .req    (rd_req),
    .update (rd_start),
    .winner (rd_winner)
  );

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      rd_state <= RD_IDLE;
      rd_owner <= 1'b0;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          if (rd_start) begin
            rd_owner <= rd_winner;
            rd_state <= RD_ADDR;
          end
        end
        RD_ADDR: if (rd_ar_hs)   rd_state <= RD_DATA;
        RD_DATA: if (rd_last_hs) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_comb begin
    m_axi.ar     = '0;
    m_axi.rready = 1'b0;
    if (rd_state == RD_ADDR) m_axi.ar     = rd_ar_sel;
    if (rd_state == RD_DATA) m_axi.rready = rd_rready_sel;
  end

  always_comb begin
    s_instr.arready = 1'b0;
    s_data.arready  = 1'b0;
    // Payload fans out to both; only the owner ever sees valid.
    s_instr.r       = m_axi.r;
    s_data.r        = m_axi.r;
    s_instr.r.valid = 1'b0;
    s_data.r.valid  = 1'b0;
    if (rd_state == RD_ADDR) begin
      if (rd_owner) s_data.arready  = m_axi.arready;
      else          s_instr.arready = m_axi.arready;
    end
    if (rd_state == RD_DATA) begin
      if (rd_owner) s_data.r.valid  = m_axi.r.valid;
      else          s_instr.r.valid = m_axi.r.valid;
    end
  end

  assign o_rd_grant = (rd_state == RD_IDLE) ? 2'b00 : grant_of(rd_owner);

  // --------------------------------------------------------------- write path
  arb_wr_state_t wr_state;
  logic          wr_owner;
  logic [1:0]    wr_req;
  logic          wr_winner;
  logic          wr_start;
  axi_ax_t       wr_aw_sel;
  axi_w_t        wr_w_sel;
  logic          wr_bready_sel;
  logic          wr_aw_hs;
  logic          wr_last_hs;
  logic          wr_b_hs;

  assign wr_req        = {s_data.aw.valid, s_instr.aw.valid};
  assign wr_start      = (wr_state == WR_IDLE) && (|wr_req);
  assign wr_aw_sel     = wr_owner ? s_data.aw : s_instr.aw;
  assign wr_w_sel      = wr_owner ? s_data.w : s_instr.w;
  assign wr_bready_sel = wr_owner ? s_data.bready : s_instr.bready;
  assign wr_aw_hs      = (wr_state == WR_ADDR) && m_axi.aw.valid && m_axi.awready;
  assign wr_last_hs    = (wr_state == WR_DATA) && m_axi.w.valid && m_axi.wready
                         && m_axi.w.last;
  assign wr_b_hs       = (wr_state == WR_RESP) && m_axi.b.valid && m_axi.bready;

  axi_rr_picker #(.RR_ENABLE(RR_ENABLE)) u_wr_pick (
    .clk    (i_aclk),
    .rst    (i_areset),
    .req    (wr_req),
    .update (wr_start),
    .winner (wr_winner)
  );

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      wr_state <= WR_IDLE;
      wr_owner <= 1'b0;
    end else begin
      unique case (wr_state)
        WR_IDLE: begin
          if (wr_start) begin
            wr_owner <= wr_winner;
            wr_state <= WR_ADDR;
          end
        end
        WR_ADDR: if (wr_aw_hs)   wr_state <= WR_DATA;
        WR_DATA: if (wr_last_hs) wr_state <= WR_RESP;
        WR_RESP: if (wr_b_hs)    wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // w is only opened after the aw handshake, so early write data from the
  // owner just waits with wready low.
  always_comb begin
    m_axi.aw     = '0;
    m_axi.w      = '0;
    m_axi.bready = 1'b0;
    if (wr_state == WR_ADDR) m_axi.aw     = wr_aw_sel;
    if (wr_state == WR_DATA) m_axi.w      = wr_w_sel;
    if (wr_state == WR_RESP) m_axi.bready = wr_bready_sel;
  end

  always_comb begin
    s_instr.awready = 1'b0;
    s_data.awready  = 1'b0;
    s_instr.wready  = 1'b0;
    s_data.wready   = 1'b0;
    s_instr.b       = m_axi.b;
    s_data.b        = m_axi.b;
    s_instr.b.valid = 1'b0;
    s_data.b.valid  = 1'b0;
    unique case (wr_state)
      WR_ADDR: begin
        if (wr_owner) s_data.awready  = m_axi.awready;
        else          s_instr.awready = m_axi.awready;
      end
      WR_DATA: begin
        if (wr_owner) s_data.wready  = m_axi.wready;
        else          s_instr.wready = m_axi.wready;
      end
      WR_RESP: begin
        if (wr_owner) s_data.b.valid  = m_axi.b.valid;
        else          s_instr.b.valid = m_axi.b.valid;
      end
      default: ;
    endcase
  end

  assign o_wr_grant = (wr_state == WR_IDLE) ? 2'b00 : grant_of(wr_owner);

endmodule

// File: tb/tb_axi_core_arbiter.sv
// Bench for axi_core_arbiter: directed scenarios plus randomized bursts
// checked against a small rule-level model (last-winner bits, pending
// request tables, expected read-data queue).
module tb_axi_core_arbiter;
  import multicore_pkg::*;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_inf instr_if ();
  axi_inf data_if ();
  axi_inf m_if ();
  logic [1:0] rd_grant, wr_grant;

  axi_core_arbiter #(.RR_ENABLE(1'b1)) dut (
    .i_aclk(clk), .i_areset(rst),
    .s_instr(instr_if), .s_data(data_if), .m_axi(m_if),
    .o_rd_grant(rd_grant), .o_wr_grant(wr_grant)
  );

  // Second instance in fixed-priority mode.
  axi_inf fi ();
  axi_inf fd ();
  axi_inf fm ();
  logic [1:0] fp_rd_grant, fp_wr_grant;

  axi_core_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
    .i_aclk(clk), .i_areset(rst),
    .s_instr(fi), .s_data(fd), .m_axi(fm),
    .o_rd_grant(fp_rd_grant), .o_wr_grant(fp_wr_grant)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ scoreboard/model
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  bit          last_rd = 1'b0;   // 0 instr, 1 data
  bit          last_wr = 1'b0;
  bit          rpend [2];
  logic [31:0] raddr [2];
  logic [7:0]  rlen  [2];
  bit          wpend [2];
  logic [31:0] waddr [2];
  logic [7:0]  wlen  [2];
  logic [31:0] wd    [4];
  logic [1:0]  wresp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Contention goes to whoever did not win last; a lone requester wins.
  function automatic bit pick(input bit req_i, input bit req_d, input bit last);
    if (req_i && req_d) return !last;
    return req_d;
  endfunction

  // ------------------------------------------------------ driver tasks
  task automatic drive_ar(input bit who, input logic v, input logic [31:0] a, input logic [7:0] l);
    axi_ax_t x;
    x = '0;
    if (v) begin x.valid = 1'b1; x.addr = a; x.len = l; x.size = 3'd2; x.burst = 2'b01; end
    if (who) data_if.ar = x; else instr_if.ar = x;
  endtask

  task automatic drive_aw(input bit who, input logic v, input logic [31:0] a, input logic [7:0] l);
    axi_ax_t x;
    x = '0;
    if (v) begin x.valid = 1'b1; x.addr = a; x.len = l; x.size = 3'd2; x.burst = 2'b01; end
    if (who) data_if.aw = x; else instr_if.aw = x;
  endtask

  task automatic drive_w(input bit who, input logic v, input logic [31:0] d, input logic last);
    axi_w_t x;
    x = '0;
    if (v) begin x.valid = 1'b1; x.data = d; x.strb = 4'hf; x.last = last; end
    if (who) data_if.w = x; else instr_if.w = x;
  endtask

  task automatic set_rready(input bit who, input logic v);
    if (who) data_if.rready = v; else instr_if.rready = v;
  endtask

  task automatic set_bready(input bit who, input logic v);
    if (who) data_if.bready = v; else instr_if.bready = v;
  endtask

  function automatic logic up_arready(input bit who);
    return who ? data_if.arready : instr_if.arready;
  endfunction
  function automatic logic up_awready(input bit who);
    return who ? data_if.awready : instr_if.awready;
  endfunction
  function automatic logic up_wready(input bit who);
    return who ? data_if.wready : instr_if.wready;
  endfunction
  function automatic axi_r_t up_r(input bit who);
    return who ? data_if.r : instr_if.r;
  endfunction
  function automatic axi_b_t up_b(input bit who);
    return who ? data_if.b : instr_if.b;
  endfunction

  // Serves one read burst for whichever master the rules say wins now.
  task automatic rd_burst(input bit rereq);
    int cyc;
    int nb;
    bit w;
    logic [31:0] d;
    axi_r_t ro;
    w = pick(rpend[0], rpend[1], last_rd);
    last_rd = w;
    cyc = 0;
    while (m_if.ar.valid !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("rd_latency", 64'(cyc), 64'd1);
    chk("rd_grant", rd_grant, w ? 2'b10 : 2'b01);
    chk("rd_araddr", m_if.ar.addr, raddr[w]);
    chk("rd_arlen", m_if.ar.len, rlen[w]);
    m_if.arready = 1'b1;
    #1;
    chk("rd_arready_own", up_arready(w), 1'b1);
    chk("rd_arready_other", up_arready(!w), 1'b0);
    @(posedge clk); #1;
    m_if.arready = 1'b0;
    rpend[w] = 1'b0;
    nb = int'(rlen[w]) + 1;
    if (rereq) begin
      raddr[w] = $urandom & 32'hffff_fff0;
      rlen[w]  = 8'($urandom_range(0, 3));
      rpend[w] = 1'b1;
      drive_ar(w, 1'b1, raddr[w], rlen[w]);
    end else begin
      drive_ar(w, 1'b0, 32'h0, 8'h0);
    end
    set_rready(w, 1'b1);
    for (int b = 0; b < nb; b++) begin
      d = $urandom;
      exp_q.push_back(d);
      m_if.r.valid = 1'b1;
      m_if.r.data  = d;
      m_if.r.resp  = AXI_RESP_OKAY;
      m_if.r.last  = (b == nb - 1);
      #1;
      ro = up_r(w);
      chk("rd_rvalid_own", ro.valid, 1'b1);
      chk("rd_rdata", ro.data, exp_q.pop_front());
      chk("rd_rlast", ro.last, (b == nb - 1));
      ro = up_r(!w);
      chk("rd_rvalid_other", ro.valid, 1'b0);
      chk("rd_rready_m", m_if.rready, 1'b1);
      @(posedge clk); #1;
    end
    m_if.r = '0;
    set_rready(w, 1'b0);
    #1;
    chk("rd_grant_idle", rd_grant, 2'b00);
    chk("rd_state_idle", dut.rd_state, RD_IDLE);
  endtask

  // Serves one write burst; beat data comes from wd[], response from wresp.
  task automatic wr_burst();
    int cyc;
    int nb;
    bit w;
    axi_b_t bo;
    w = pick(wpend[0], wpend[1], last_wr);
    last_wr = w;
    cyc = 0;
    while (m_if.aw.valid !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("wr_latency", 64'(cyc), 64'd1);
    chk("wr_grant", wr_grant, w ? 2'b10 : 2'b01);
    chk("wr_awaddr", m_if.aw.addr, waddr[w]);
    chk("wr_awlen", m_if.aw.len, wlen[w]);
    nb = int'(wlen[w]) + 1;
    // Offer data before the aw handshake: it must be held off.
    drive_w(w, 1'b1, wd[0], (nb == 1));
    m_if.wready = 1'b1;
    #1;
    chk("wr_wvalid_early", m_if.w.valid, 1'b0);
    chk("wr_wready_early", up_wready(w), 1'b0);
    m_if.awready = 1'b1;
    #1;
    chk("wr_awready_own", up_awready(w), 1'b1);
    chk("wr_awready_other", up_awready(!w), 1'b0);
    @(posedge clk); #1;
    m_if.awready = 1'b0;
    wpend[w] = 1'b0;
    drive_aw(w, 1'b0, 32'h0, 8'h0);
    for (int b = 0; b < nb; b++) begin
      drive_w(w, 1'b1, wd[b], (b == nb - 1));
      #1;
      chk("wr_wvalid_m", m_if.w.valid, 1'b1);
      chk("wr_wdata", m_if.w.data, wd[b]);
      chk("wr_wstrb", m_if.w.strb, 4'hf);
      chk("wr_wlast", m_if.w.last, (b == nb - 1));
      chk("wr_wready_own", up_wready(w), 1'b1);
      chk("wr_wready_other", up_wready(!w), 1'b0);
      @(posedge clk); #1;
    end
    drive_w(w, 1'b0, 32'h0, 1'b0);
    m_if.wready  = 1'b0;
    m_if.b.valid = 1'b1;
    m_if.b.resp  = wresp;
    set_bready(w, 1'b1);
    #1;
    bo = up_b(w);
    chk("wr_bvalid_own", bo.valid, 1'b1);
    chk("wr_bresp", bo.resp, wresp);
    bo = up_b(!w);
    chk("wr_bvalid_other", bo.valid, 1'b0);
    chk("wr_bready_m", m_if.bready, 1'b1);
    @(posedge clk); #1;
    m_if.b = '0;
    set_bready(w, 1'b0);
    #1;
    chk("wr_grant_idle", wr_grant, 2'b00);
    chk("wr_state_idle", dut.wr_state, WR_IDLE);
  endtask

  task automatic clear_all();
    instr_if.ar = '0; instr_if.aw = '0; instr_if.w = '0; instr_if.rready = 0; instr_if.bready = 0;
    data_if.ar  = '0; data_if.aw  = '0; data_if.w  = '0; data_if.rready  = 0; data_if.bready  = 0;
    m_if.arready = 0; m_if.awready = 0; m_if.wready = 0; m_if.r = '0; m_if.b = '0;
    fi.ar = '0; fi.aw = '0; fi.w = '0; fi.rready = 0; fi.bready = 0;
    fd.ar = '0; fd.aw = '0; fd.w = '0; fd.rready = 0; fd.bready = 0;
    fm.arready = 0; fm.awready = 0; fm.wready = 0; fm.r = '0; fm.b = '0;
  endtask

  // ------------------------------------------------------ directed sequence
  initial begin
    axi_ax_t x;
    int starts;
    logic [1:0] prev;
    int mode;

    clear_all();
    rpend = '{1'b0, 1'b0};
    wpend = '{1'b0, 1'b0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_rd_grant", rd_grant, 2'b00);
    chk("rst_wr_grant", wr_grant, 2'b00);
    chk("rst_m_arvalid", m_if.ar.valid, 1'b0);
    chk("rst_m_awvalid", m_if.aw.valid, 1'b0);
    chk("rst_m_wvalid", m_if.w.valid, 1'b0);
    chk("rst_m_rready", m_if.rready, 1'b0);
    chk("rst_m_bready", m_if.bready, 1'b0);
    chk("rst_m_araddr", m_if.ar.addr, 32'h0);
    chk("rst_up_arready", instr_if.arready, 1'b0);
    chk("rst_up_rvalid", data_if.r.valid, 1'b0);
    chk("rst_rd_state", dut.rd_state, RD_IDLE);
    chk("rst_wr_state", dut.wr_state, WR_IDLE);
    rst = 1'b0;

    // Single instruction read, 4 beats
    raddr[0] = 32'h100; rlen[0] = 8'd3; rpend[0] = 1'b1;
    drive_ar(1'b0, 1'b1, raddr[0], rlen[0]);
    rd_burst(1'b0);

    // Contention: data first, then instr; then a round where data re-requests
    raddr[0] = 32'h1000; rlen[0] = 8'd1; rpend[0] = 1'b1;
    raddr[1] = 32'h2000; rlen[1] = 8'd2; rpend[1] = 1'b1;
    drive_ar(1'b0, 1'b1, raddr[0], rlen[0]);
    drive_ar(1'b1, 1'b1, raddr[1], rlen[1]);
    rd_burst(1'b0);
    rd_burst(1'b0);
    raddr[0] = 32'h1100; rlen[0] = 8'd0; rpend[0] = 1'b1;
    raddr[1] = 32'h2100; rlen[1] = 8'd1; rpend[1] = 1'b1;
    drive_ar(1'b0, 1'b1, raddr[0], rlen[0]);
    drive_ar(1'b1, 1'b1, raddr[1], rlen[1]);
    rd_burst(1'b1);
    rd_burst(1'b0);
    rd_burst(1'b0);

    // Data write with SLVERR
    waddr[1] = 32'h3000; wlen[1] = 8'd1; wpend[1] = 1'b1;
    wd[0] = 32'hDEADBEEF; wd[1] = 32'hCAFEF00D; wresp = AXI_RESP_SLVERR;
    drive_aw(1'b1, 1'b1, waddr[1], wlen[1]);
    wr_burst();

    // Randomized writes
    for (int it = 0; it < 6; it++) begin
      mode = int'($urandom_range(0, 2));
      for (int m = 0; m < 2; m++) begin
        if (mode == 2 || mode == m) begin
          waddr[m] = $urandom & 32'hffff_fff0;
          wlen[m]  = 8'($urandom_range(0, 3));
          wpend[m] = 1'b1;
          drive_aw(m[0], 1'b1, waddr[m], wlen[m]);
        end
      end
      while (wpend[0] || wpend[1]) begin
        for (int b = 0; b < 4; b++) wd[b] = $urandom;
        wresp = 2'($urandom_range(0, 3));
        wr_burst();
      end
    end

    // Randomized reads
    for (int it = 0; it < 16; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!rpend[m] && $urandom_range(0, 1) == 1) begin
          raddr[m] = $urandom & 32'hffff_fff0;
          rlen[m]  = 8'($urandom_range(0, 3));
          rpend[m] = 1'b1;
          drive_ar(m[0], 1'b1, raddr[m], rlen[m]);
        end
      end
      if (!rpend[0] && !rpend[1]) begin
        raddr[0] = $urandom & 32'hffff_fff0;
        rlen[0]  = 8'($urandom_range(0, 3));
        rpend[0] = 1'b1;
        drive_ar(1'b0, 1'b1, raddr[0], rlen[0]);
      end
      rd_burst(1'($urandom_range(0, 1)));
    end
    while (rpend[0] || rpend[1]) rd_burst(1'b0);

    // Concurrent instr read and data write
    drive_ar(1'b0, 1'b1, 32'h400, 8'd0);
    drive_aw(1'b1, 1'b1, 32'h500, 8'd0);
    last_rd = pick(1'b1, 1'b0, last_rd);
    last_wr = pick(1'b0, 1'b1, last_wr);
    @(posedge clk); #1;
    chk("cc_rd_grant", rd_grant, GRANT_INSTR);
    chk("cc_wr_grant", wr_grant, GRANT_DATA);
    chk("cc_m_arvalid", m_if.ar.valid, 1'b1);
    chk("cc_m_awaddr", m_if.aw.addr, 32'h500);
    m_if.arready = 1'b1; m_if.awready = 1'b1;
    @(posedge clk); #1;
    m_if.arready = 1'b0; m_if.awready = 1'b0;
    drive_ar(1'b0, 1'b0, 32'h0, 8'h0);
    drive_aw(1'b1, 1'b0, 32'h0, 8'h0);
    m_if.r.valid = 1'b1; m_if.r.data = 32'h11112222; m_if.r.last = 1'b1;
    set_rready(1'b0, 1'b1);
    drive_w(1'b1, 1'b1, 32'h33334444, 1'b1);
    m_if.wready = 1'b1;
    #1;
    chk("cc_rvalid", instr_if.r.valid, 1'b1);
    chk("cc_rdata", instr_if.r.data, 32'h11112222);
    chk("cc_wdata", m_if.w.data, 32'h33334444);
    chk("cc_wready", data_if.wready, 1'b1);
    @(posedge clk); #1;
    m_if.r = '0; set_rready(1'b0, 1'b0);
    drive_w(1'b1, 1'b0, 32'h0, 1'b0); m_if.wready = 1'b0;
    chk("cc_rd_done", rd_grant, 2'b00);
    chk("cc_wr_resp_grant", wr_grant, GRANT_DATA);
    m_if.b.valid = 1'b1; m_if.b.resp = AXI_RESP_OKAY;
    set_bready(1'b1, 1'b1);
    #1;
    chk("cc_bvalid", data_if.b.valid, 1'b1);
    @(posedge clk); #1;
    m_if.b = '0; set_bready(1'b1, 1'b0);
    chk("cc_wr_done", wr_grant, 2'b00);

    // Reset during beat 2 of a 4-beat read
    drive_ar(1'b0, 1'b1, 32'h600, 8'd3);
    @(posedge clk); #1;
    m_if.arready = 1'b1;
    @(posedge clk); #1;
    m_if.arready = 1'b0;
    drive_ar(1'b0, 1'b0, 32'h0, 8'h0);
    set_rready(1'b0, 1'b1);
    m_if.r.valid = 1'b1; m_if.r.data = 32'h0A0A0001; m_if.r.last = 1'b0;
    #1;
    chk("rr_beat1", instr_if.r.data, 32'h0A0A0001);
    @(posedge clk); #1;
    m_if.r.data = 32'h0A0A0002;
    rst = 1'b1;
    #1;
    chk("rr_beat2_valid", instr_if.r.valid, 1'b1);
    @(posedge clk); #1;
    chk("rr_m_rready", m_if.rready, 1'b0);
    chk("rr_rd_grant", rd_grant, 2'b00);
    chk("rr_rd_state", dut.rd_state, RD_IDLE);
    chk("rr_up_rvalid", instr_if.r.valid, 1'b0);
    rst = 1'b0;
    clear_all();
    last_rd = 1'b0; last_wr = 1'b0;
    exp_q.delete();
    raddr[0] = 32'h700; rlen[0] = 8'd2; rpend[0] = 1'b1;
    drive_ar(1'b0, 1'b1, raddr[0], rlen[0]);
    rd_burst(1'b0);

    // Fixed priority: both request forever, instr must never be granted
    x = '0; x.valid = 1'b1; x.len = 8'd0; x.size = 3'd2; x.burst = 2'b01;
    x.addr = 32'h8000; fi.ar = x;
    x.addr = 32'h9000; fd.ar = x;
    fi.rready = 1'b1; fd.rready = 1'b1;
    fm.arready = 1'b1;
    fm.r.valid = 1'b1; fm.r.last = 1'b1; fm.r.data = 32'h5A5A5A5A;
    starts = 0;
    prev = 2'b00;
    repeat (30) begin
      @(posedge clk); #1;
      chk("fp_no_instr_grant", (fp_rd_grant == GRANT_INSTR), 1'b0);
      chk("fp_instr_arready", fi.arready, 1'b0);
      if (fp_rd_grant == GRANT_DATA && prev == 2'b00) starts++;
      prev = fp_rd_grant;
    end
    chk("fp_data_grants", (starts >= 9), 1'b1);
    clear_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
